// File: rtl/reg_file_p.sv
// Register file with hidden temporaries, optional write-to-read forwarding,
// optional hard-wired zero register and a one-register-per-cycle clear sweep.
module reg_file_p #(
    parameter  int WIDTH   = 8,
    parameter  int NREG    = 8,
    parameter  int NTMP    = 1,
    parameter  int BYPASS  = 1,
    parameter  int ZERO_R0 = 0,
    localparam int NTOT    = NREG + NTMP,
    localparam int AW      = (NTOT <= 2) ? 1 : $clog2(NTOT)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [AW-1:0]    AA,
    input  logic [AW-1:0]    BA,
    input  logic [AW-1:0]    DA,
    input  logic             RW,
    input  logic [WIDTH-1:0] DDATA,
    input  logic             CLR,
    output logic [WIDTH-1:0] ADATA,
    output logic [WIDTH-1:0] BDATA,
    output logic             BUSY,
    output logic             DONE
);

    // One extra bit so NTOT is representable even when it is a power of two.
    localparam logic [AW:0]   NTOT_A = (AW + 1)'(NTOT);
    localparam logic [AW-1:0] LAST   = AW'(NTOT - 1);

    typedef enum logic {IDLE, SWEEP} state_e;

    state_e           state_q;
    logic [AW-1:0]    cnt_q;
    logic [AW-1:0]    cnt_d;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] regs_q [NTOT];
    logic             wrQual;
    logic             wrAddrOk;

    assign wrAddrOk = ({1'b0, DA} < NTOT_A) && !((ZERO_R0 != 0) && (DA == '0));
    assign wrQual   = RW && !busy_q && !RST && wrAddrOk;
    assign cnt_d    = cnt_q + AW'(1);

    assign BUSY = busy_q;
    assign DONE = done_q;

    always_comb begin
        ADATA = '0;
        if (({1'b0, AA} < NTOT_A) && !((ZERO_R0 != 0) && (AA == '0))) begin
            ADATA = regs_q[AA];
        end
        if ((BYPASS != 0) && wrQual && (AA == DA)) begin
            ADATA = DDATA;
        end
    end

    always_comb begin
        BDATA = '0;
        if (({1'b0, BA} < NTOT_A) && !((ZERO_R0 != 0) && (BA == '0))) begin
            BDATA = regs_q[BA];
        end
        if ((BYPASS != 0) && wrQual && (BA == DA)) begin
            BDATA = DDATA;
        end
    end

    // The sweep owns the write port while busy, so user writes are dropped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NTOT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (busy_q) begin
            regs_q[cnt_q] <= '0;
        end else if (wrQual) begin
            regs_q[DA] <= DDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (CLR) begin
                        state_q <= SWEEP;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (cnt_q == LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_p.sv
// Bench for reg_file_p: three instances (default, no forwarding, hard-zero r0)
// share stimulus and are compared against an array-based behavioural model.
module tb_reg_file_p;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RW;
    logic       CLR;
    logic [3:0] AA;
    logic [3:0] BA;
    logic [3:0] DA;
    logic [7:0] DDATA;

    logic [7:0] aData [3];
    logic [7:0] bData [3];
    logic       busy  [3];
    logic       done  [3];

    // Model: register contents per instance, next index to clear (-1 = idle).
    logic [7:0] mdl [3][9];
    int         sweepIdx;
    bit         doneExp;
    int         checks;
    int         failures;

    reg_file_p dut0 (
        .CLK(CLK), .RST(RST), .AA(AA), .BA(BA), .DA(DA), .RW(RW), .DDATA(DDATA), .CLR(CLR),
        .ADATA(aData[0]), .BDATA(bData[0]), .BUSY(busy[0]), .DONE(done[0])
    );

    reg_file_p #(.BYPASS(0)) dut1 (
        .CLK(CLK), .RST(RST), .AA(AA), .BA(BA), .DA(DA), .RW(RW), .DDATA(DDATA), .CLR(CLR),
        .ADATA(aData[1]), .BDATA(bData[1]), .BUSY(busy[1]), .DONE(done[1])
    );

    reg_file_p #(.ZERO_R0(1)) dut2 (
        .CLK(CLK), .RST(RST), .AA(AA), .BA(BA), .DA(DA), .RW(RW), .DDATA(DDATA), .CLR(CLR),
        .ADATA(aData[2]), .BDATA(bData[2]), .BUSY(busy[2]), .DONE(done[2])
    );

    always #10 CLK = ~CLK;

    function automatic bit wrOk(int inst);
        return RW && !RST && (sweepIdx < 0) && (DA < 4'd9) && !(inst == 2 && DA == 4'd0);
    endfunction

    function automatic logic [7:0] expRead(int inst, logic [3:0] addr);
        if (addr >= 4'd9 || (inst == 2 && addr == 4'd0)) return 8'h00;
        if (inst != 1 && wrOk(inst) && addr == DA) return DDATA;
        return mdl[inst][addr];
    endfunction

    // Advance one clock and apply the register-file rules to the model.
    task automatic tick();
        @(posedge CLK);
        if (RST) begin
            for (int i = 0; i < 3; i++) for (int r = 0; r < 9; r++) mdl[i][r] = 8'h00;
            sweepIdx = -1;
            doneExp  = 1'b0;
        end else if (sweepIdx >= 0) begin
            for (int i = 0; i < 3; i++) mdl[i][sweepIdx] = 8'h00;
            doneExp  = (sweepIdx == 8);
            sweepIdx = (sweepIdx == 8) ? -1 : sweepIdx + 1;
        end else begin
            doneExp = 1'b0;
            for (int i = 0; i < 3; i++) if (wrOk(i)) mdl[i][DA] = DDATA;
            if (CLR) sweepIdx = 0;
        end
        #1;
    endtask

    task automatic writeReg(logic [3:0] addr, logic [7:0] data);
        RW = 1'b1; DA = addr; DDATA = data; CLR = 1'b0; RST = 1'b0;
        tick();
        RW = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; RW = 1'b1; DA = 4'd3; DDATA = 8'h5A; CLR = 1'b1;
        tick();
        for (int a = 0; a < 16; a++) begin
            AA = 4'(a); BA = 4'(15 - a); #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (aData[i] !== 8'h00 || bData[i] !== 8'h00) begin
                    failures++;
                    $display("[TB] FAIL reset_read inst=%0d addr=%0d got=%h/%h exp=00/00", i, a, aData[i], bData[i]);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy[i] !== 1'b0 || done[i] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_flags inst=%0d got busy=%b done=%b exp 0/0", i, busy[i], done[i]);
            end
        end
        RST = 1'b0; RW = 1'b0; CLR = 1'b0;
    endtask

    task automatic test_bypass();
        RW = 1'b1; DA = 4'd3; DDATA = 8'hA5; AA = 4'd3; BA = 4'd3; #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bData[i] !== expRead(i, BA)) begin
                failures++;
                $display("[TB] FAIL bypass_same_cycle inst=%0d got=%h exp=%h", i, bData[i], expRead(i, BA));
            end
        end
        tick();
        RW = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (aData[i] !== 8'hA5 || bData[i] !== 8'hA5) begin
                failures++;
                $display("[TB] FAIL bypass_next_cycle inst=%0d got=%h/%h exp=a5/a5", i, aData[i], bData[i]);
            end
        end
    endtask

    task automatic test_zero_r0();
        RW = 1'b1; DA = 4'd0; DDATA = 8'hFF; AA = 4'd0; BA = 4'd0; #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (aData[i] !== expRead(i, AA)) begin
                failures++;
                $display("[TB] FAIL zero_r0_fwd inst=%0d got=%h exp=%h", i, aData[i], expRead(i, AA));
            end
        end
        tick();
        DA = 4'd9; AA = 4'd9; BA = 4'd0; #1;
        checks++;
        if (aData[0] !== 8'h00 || bData[2] !== 8'h00 || bData[0] !== 8'hFF) begin
            failures++;
            $display("[TB] FAIL zero_r0_oob got a0=%h b2=%h b0=%h exp 00/00/ff", aData[0], bData[2], bData[0]);
        end
        tick();
        RW = 1'b0;
        for (int a = 0; a < 16; a++) begin
            AA = 4'(a); #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (aData[i] !== expRead(i, AA)) begin
                    failures++;
                    $display("[TB] FAIL zero_r0_scan inst=%0d addr=%0d got=%h exp=%h", i, a, aData[i], expRead(i, AA));
                end
            end
        end
    endtask

    task automatic test_sweep();
        int busyCnt = 0;
        int doneCnt = 0;
        RST = 1'b1; tick(); RST = 1'b0;
        for (int k = 0; k < 9; k++) writeReg(4'(k), 8'(17 * (k + 1)));
        CLR = 1'b1; tick(); CLR = 1'b0;
        for (int c = 0; c < 14; c++) begin
            RW = (c < 9); DA = 4'($urandom_range(0, 8)); DDATA = 8'($urandom);
            for (int a = 0; a < 9; a++) begin
                AA = 4'(a); BA = 4'(8 - a); #1;
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (aData[i] !== expRead(i, AA) || bData[i] !== expRead(i, BA)) begin
                        failures++;
                        $display("[TB] FAIL sweep_read inst=%0d c=%0d a=%0d got=%h/%h exp=%h/%h", i, c, a,
                                 aData[i], bData[i], expRead(i, AA), expRead(i, BA));
                    end
                end
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (busy[i] !== 1'(sweepIdx >= 0) || done[i] !== doneExp) begin
                    failures++;
                    $display("[TB] FAIL sweep_flags inst=%0d c=%0d got=%b/%b exp=%b/%b", i, c, busy[i], done[i],
                             sweepIdx >= 0, doneExp);
                end
            end
            if (busy[0] === 1'b1) busyCnt++;
            if (done[0] === 1'b1) doneCnt++;
            tick();
        end
        RW = 1'b0;
        checks++;
        if (busyCnt != 9 || doneCnt != 1) begin
            failures++;
            $display("[TB] FAIL sweep_counts got busy=%0d done=%0d exp busy=9 done=1", busyCnt, doneCnt);
        end
    endtask

    task automatic test_reset_mid_sweep();
        for (int k = 0; k < 9; k++) writeReg(4'(k), 8'($urandom_range(1, 255)));
        CLR = 1'b1; tick(); CLR = 1'b0;
        tick(); tick(); tick();
        RST = 1'b1; tick(); RST = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int a = 0; a < 9; a++) begin
                AA = 4'(a); BA = 4'(a); #1;
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (aData[i] !== 8'h00 || busy[i] !== 1'b0 || done[i] !== 1'b0) begin
                        failures++;
                        $display("[TB] FAIL abort_sweep inst=%0d a=%0d got data=%h busy=%b done=%b exp 00/0/0",
                                 i, a, aData[i], busy[i], done[i]);
                    end
                end
            end
            tick();
        end
    endtask

    task automatic test_clr_with_write();
        CLR = 1'b1; RW = 1'b1; DA = 4'd8; DDATA = 8'h3C; AA = 4'd8; #1;
        checks++;
        if (aData[0] !== 8'h3C) begin
            failures++;
            $display("[TB] FAIL clr_write_fwd got=%h exp=3c", aData[0]);
        end
        tick();
        RW = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            CLR = (c >= 2 && c <= 5); #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (aData[i] !== ((c <= 9) ? 8'h3C : 8'h00) || busy[i] !== 1'(c <= 9)) begin
                    failures++;
                    $display("[TB] FAIL clr_write_sweep inst=%0d c=%0d got=%h busy=%b exp=%h busy=%b", i, c,
                             aData[i], busy[i], (c <= 9) ? 8'h3C : 8'h00, c <= 9);
                end
            end
            tick();
        end
        CLR = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            RST   = ($urandom_range(0, 49) == 0);
            CLR   = ($urandom_range(0, 19) == 0);
            RW    = 1'($urandom_range(0, 1));
            DA    = 4'($urandom_range(0, 15));
            DDATA = 8'($urandom);
            AA    = 4'($urandom_range(0, 15));
            BA    = ($urandom_range(0, 2) == 0) ? DA : 4'($urandom_range(0, 15));
            #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (aData[i] !== expRead(i, AA) || bData[i] !== expRead(i, BA) ||
                    busy[i] !== 1'(sweepIdx >= 0) || done[i] !== doneExp) begin
                    failures++;
                    $display("[TB] FAIL random n=%0d inst=%0d got a=%h b=%h busy=%b done=%b exp a=%h b=%h busy=%b done=%b",
                             n, i, aData[i], bData[i], busy[i], done[i], expRead(i, AA), expRead(i, BA),
                             sweepIdx >= 0, doneExp);
                end
            end
            tick();
        end
        RST = 1'b0; CLR = 1'b0; RW = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0; sweepIdx = -1; doneExp = 1'b0;
        for (int i = 0; i < 3; i++) for (int r = 0; r < 9; r++) mdl[i][r] = 8'h00;
        RST = 1'b1; RW = 1'b0; CLR = 1'b0; AA = '0; BA = '0; DA = '0; DDATA = '0;
        #1;
        test_reset();
        test_bypass();
        test_zero_r0();
        test_sweep();
        test_reset_mid_sweep();
        test_clr_with_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_p.md
REG_FILE_P -- requirements
Module: reg_file_p

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of every register and data port.
REQ-002 SHALL have parameter NREG, default 8, number of user-visible registers, at addresses 0..NREG-1.
REQ-003 SHALL have parameter NTMP, default 1, number of hidden temporary registers, at addresses NREG..NREG+NTMP-1.
REQ-004 SHALL have parameter BYPASS, default 1, where 1 enables write-to-read forwarding.
REQ-005 SHALL have parameter ZERO_R0, default 0, where 1 makes register 0 read as 0 and ignore writes.
REQ-006 SHALL derive local NTOT = NREG+NTMP and AW = max(1, clog2(NTOT)).
REQ-007 SHALL have port CLK, input, 1, sole clock; all state changes on its rising edge.
REQ-008 SHALL have port RST, input, 1, reset; synchronous and active-high.
REQ-009 SHALL have port AA, input, AW, read address for port A.
REQ-010 SHALL have port BA, input, AW, read address for port B.
REQ-011 SHALL have port DA, input, AW, write address.
REQ-012 SHALL have port RW, input, 1, write enable.
REQ-013 SHALL have port DDATA, input, WIDTH, write data.
REQ-014 SHALL have port CLR, input, 1, request to start a clear sweep.
REQ-015 SHALL have port ADATA, output, WIDTH, read data for port A (combinational).
REQ-016 SHALL have port BDATA, output, WIDTH, read data for port B (combinational).
REQ-017 SHALL have port BUSY, output, 1, high while a clear sweep is in progress.
REQ-018 SHALL have port DONE, output, 1, single-cycle pulse marking the end of a sweep.

Function
REQ-019 SHALL perform a write, when RW=1, BUSY=0 and RST=0, by storing DDATA into reg[DA] at the clock edge; the stored value is readable from the next cycle.
REQ-020 SHALL ignore writes with DA>=NTOT, and SHALL ignore writes to address 0 when ZERO_R0=1.
REQ-021 SHALL drive ADATA = reg[AA] and BDATA = reg[BA] combinationally; an address >=NTOT reads 0; address 0 reads 0 when ZERO_R0=1.
REQ-022 SHALL, when BYPASS=1 and the write of REQ-019 is qualified in the current cycle, drive ADATA=DDATA if AA==DA and BDATA=DDATA if BA==DA (same cycle); no forwarding for ignored writes.
REQ-023 SHALL implement an FSM with states IDLE and SWEEP, plus an index counter CNT of width AW.
REQ-024 SHALL, in IDLE with CLR=1 sampled, enter SWEEP next cycle with CNT=0; BUSY=1 exactly while in SWEEP.
REQ-025 SHALL, in SWEEP, clear reg[CNT] to 0 each cycle and increment CNT; when CNT==NTOT-1, clear that register and return to IDLE.
REQ-026 SHALL assert DONE for exactly one cycle, in the first IDLE cycle after a sweep; a sweep therefore takes NTOT BUSY cycles.
REQ-027 SHALL ignore CLR while in SWEEP (no restart, no queueing).
REQ-028 SHALL, when CLR=1 and a qualified write occur in the same IDLE cycle, perform the write; the following sweep then clears it.
REQ-029 SHALL ignore RW while BUSY=1; reads during SWEEP return current contents (already-swept registers read 0).

Reset
REQ-030 SHALL, when RST=1 at a clock edge, clear all NTOT registers to 0 and set the FSM to IDLE, CNT=0, BUSY=0 and DONE=0; RST has priority over CLR and RW.
REQ-031 SHALL, on reset during SWEEP, abort the sweep without a DONE pulse.
REQ-032 SHALL suppress forwarding while RST=1, so that after reset ADATA=BDATA=0 for every address.

Verification
REQ-033 SHALL be verified by this scenario (defaults): write DA=3, DDATA=0xA5 -> next cycle AA=3 reads 0xA5; in the write cycle, BA=3 reads 0xA5 via bypass.
REQ-034 SHALL be verified by this scenario: BYPASS=0, same write -> BA=3 reads 0x00 in the write cycle and 0xA5 in the next cycle.
REQ-035 SHALL be verified by this scenario: fill regs 0..8 with 0x11..0x99, then pulse CLR -> BUSY high for 9 cycles, reg k reads 0 from the cycle after its clear, DONE pulses once, RW=1 during BUSY has no effect.
REQ-036 SHALL be verified by this scenario: RST asserted on the 4th cycle of a sweep -> next cycle BUSY=0, no DONE pulse, all registers read 0.
REQ-037 SHALL be verified by this scenario: ZERO_R0=1, write DA=0 with 0xFF -> AA=0 reads 0x00; DA=9 (>=NTOT) with 0xFF -> no register changes, AA=9 reads 0x00.
REQ-038 SHALL be verified by this scenario: CLR and write DA=8 (temp register) with 0x3C in the same cycle -> reg 8 reads 0x3C until the sweep reaches index 8, then reads 0x00.
